lcd4_stream_ctrl: RTL and testbench
===================================

# lcd4_stream_ctrl

Parametrised HD44780-style character-LCD controller for the 4-bit bus. After reset it plays a fixed 4-nibble init sequence, then drains a host byte FIFO, sending each byte as two nibbles (high first) with a register-select flag. It replaces the fixed-message display driver. The FIFO takes arbitrary command and data bytes from the host, and pulse width and slot period are set by parameters, so one block serves any message and any clock rate.

## Interface

**Parameters**
- `CLK_DIV`, default 64: clocks per nibble slot. Must be ≥ `E_WIDTH`+3 and ≤ 65535.
- `E_WIDTH`, default 1: clocks `lcd_e` is held high per nibble. Must be ≥ 1.
- `DEPTH`, default 8: FIFO depth in bytes. Must be a power of 2 and ≥ 2.

**Ports** (reset rst_n, synchronous, active-low; clock clk)
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `in_valid` in 1: host byte valid.
- `in_ready` out 1: FIFO can accept. Equals !full.
- `in_rs` in 1: 0 = command byte, 1 = data byte.
- `in_data` in 8: byte to send.
- `lcd_d` out 4: nibble bus.
- `lcd_rs` out 1: register select for the current nibble.
- `lcd_e` out 1: enable strobe.
- `init_done` out 1: init sequence complete.
- `busy` out 1: a transfer is in progress or the FIFO is non-empty.

## Operation

**Reset**
- Reset values: `lcd_d`=0, `lcd_rs`=0, `lcd_e`=0, `init_done`=0, `busy`=1, `in_ready`=1.
- Reset clears the slot timer `t` to 0, empties the FIFO and puts the FSM in INIT, index 0.
- Reset asserted mid-operation, including mid-pulse, has identical effect. Any partially sent byte is lost.

**Slot timer**
- `t` counts 0 to `CLK_DIV`-1 and wraps. It free-runs in every state.
- Nibble loads happen only on the edge that ends a cycle with `t`==0 (the slot start).

**FSM states**
- INIT: at slot start, drive init nibble `k` with `lcd_rs`=0. The sequence is k0=0x3, k1=0x2, k2=0x0, k3=0xE. After k3 is loaded, go to IDLE and set `init_done`=1 (visible from the same cycle as the k3 nibble).
- IDLE: at slot start, if the FIFO is non-empty, pop one byte, drive `lcd_d`=byte[7:4] and `lcd_rs`=rs, then go to LO. If the FIFO is empty, nothing is loaded: `lcd_d`/`lcd_rs` hold their last values and `lcd_e` stays 0.
- LO: at the next slot start, drive `lcd_d`=byte[3:0] with the same rs, then go to IDLE.
- Slots are back-to-back. A full FIFO therefore streams one nibble per slot with no gap between bytes.

**FIFO**
- Width 9 bits (rs and data), depth `DEPTH`.
- A push occurs when `in_valid` && `in_ready`.
- A push and a pop in the same cycle leave the count unchanged.
- A byte pushed in the same cycle as a slot-start pop on an empty FIFO is not popped. It goes out at the next slot start.
- Pointers wrap modulo `DEPTH`.
- Pushes are accepted during INIT.

**`busy`** = (state != IDLE) || FIFO non-empty || `lcd_e`.

## Timing

- A nibble loaded at slot start is visible in the cycle with `t`==1. This gives 1 cycle of setup before E.
- `lcd_e` is registered and high during the cycles with `t` in [2, `E_WIDTH`+1]. It is low otherwise.
- Data stays stable until the next slot start, so hold after E falls is ≥ `CLK_DIV`-`E_WIDTH`-2 cycles.
- Every E pulse corresponds to exactly one loaded nibble. A slot with no load produces no pulse.
- First E rising edge after reset release: cycle `t`==2 of slot 0.
- Latency from a byte accepted in IDLE with the FIFO empty and the bus idle: high nibble at the next slot start, low nibble one slot later.
- `in_ready` is combinational from the registered count. It deasserts in the cycle after the push that fills the FIFO.

## Test plan

Parameters for all scenarios: `CLK_DIV`=8, `E_WIDTH`=2, `DEPTH`=4.

1. **Reset and init.** Hold reset 3 cycles, then release.
   - Exactly 4 E pulses, each 2 cycles wide, carrying `lcd_d` 3, 2, 0, E with `lcd_rs`=0.
   - `init_done` rises with the 4th nibble.
   - After that: no further pulses and `busy`=0.
2. **Single byte.** After init, push rs=1, data 0x48.
   - Next slot: `lcd_d`=4, `lcd_rs`=1.
   - Following slot: `lcd_d`=8, `lcd_rs`=1.
   - Then `busy` falls.
3. **Fill during init.** Push 0x41, 0x42, 0x43, 0x44 during init.
   - `in_ready`=0 after the 4th push; a 5th `in_valid` is not accepted.
   - After init, nibbles 4,1,4,2,4,3,4,4 appear on 8 consecutive slots.
4. **Mixed rs.** Push cmd 0x01, then data 0x5A.
   - Nibbles 0,1 appear with `lcd_rs`=0.
   - Nibbles 5,A appear with `lcd_rs`=1.
5. **Reset mid-pulse.** Assert `rst_n`=0 during the E-high cycle of a high nibble, with 2 bytes queued.
   - `lcd_e`=0 and `lcd_d`=0 on the next edge, and `in_ready`=1.
   - After release: init 3,2,0,E replays and the queued bytes are gone.
6. **Push on the pop cycle.** Push a byte exactly in the `t`==0 cycle with the FIFO empty.
   - The byte's high nibble appears at the following slot start, not the current one.

Source files
------------

// File: rtl/lcd4_stream_ctrl.sv
// HD44780-style 4-bit LCD controller: plays a fixed init sequence, then streams
// host bytes from a FIFO as two nibbles per byte, high nibble first.
module lcd4_stream_ctrl #(
  parameter int CLK_DIV = 64,
  parameter int E_WIDTH = 1,
  parameter int DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic [3:0] lcd_d,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic       init_done,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_LO   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;

  logic [15:0] r_t;
  logic        w_slot_start;

  logic [8:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [8:0]  w_head;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;

  logic        w_load;
  logic [3:0]  w_nib;
  logic        w_nib_rs;
  logic        w_init_last;

  logic [3:0]  r_d;
  logic        r_rs;
  logic        r_e;
  logic        r_loaded;
  logic        r_init_done;
  logic [3:0]  r_lo_nib;
  logic        r_lo_rs;

  assign w_slot_start = (r_t == 16'd0);
  assign w_empty      = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign in_ready     = (r_count != (AW+1)'(DEPTH));
  assign w_push       = in_valid && in_ready;

  // Free-running slot timer; every state shares the same slot grid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_t <= 16'd0;
    end else if (r_t == 16'(CLK_DIV - 1)) begin
      r_t <= 16'd0;
    end else begin
      r_t <= r_t + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Only the count seen at slot start decides a pop, so a byte pushed in that
  // same cycle into an empty FIFO waits for the next slot.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_nib       = r_d;
    w_nib_rs    = r_rs;
    w_init_last = 1'b0;
    if (w_slot_start) begin
      case (r_state)
        S_INIT: begin
          w_load    = 1'b1;
          w_nib_rs  = 1'b0;
          w_idx_nxt = r_idx + 2'd1;
          case (r_idx)
            2'd0:    w_nib = 4'h3;
            2'd1:    w_nib = 4'h2;
            2'd2:    w_nib = 4'h0;
            default: w_nib = 4'hE;
          endcase
          if (r_idx == 2'd3) begin
            w_state_nxt = S_IDLE;
            w_init_last = 1'b1;
          end
        end
        S_IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_load      = 1'b1;
            w_nib       = w_head[7:4];
            w_nib_rs    = w_head[8];
            w_state_nxt = S_LO;
          end
        end
        S_LO: begin
          w_load      = 1'b1;
          w_nib       = r_lo_nib;
          w_nib_rs    = r_lo_rs;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_INIT;
          w_idx_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_rs, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // E follows only slots that loaded a nibble; it spans t = 2 .. E_WIDTH+1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d         <= 4'h0;
      r_rs        <= 1'b0;
      r_e         <= 1'b0;
      r_loaded    <= 1'b0;
      r_init_done <= 1'b0;
      r_lo_nib    <= 4'h0;
      r_lo_rs     <= 1'b0;
    end else begin
      if (w_load) begin
        r_d  <= w_nib;
        r_rs <= w_nib_rs;
      end
      if (w_pop) begin
        r_lo_nib <= w_head[3:0];
        r_lo_rs  <= w_head[8];
      end
      if (w_slot_start) begin
        r_loaded <= w_load;
      end
      r_e <= r_loaded && (r_t >= 16'd1) && (r_t <= 16'(E_WIDTH));
      if (w_init_last) begin
        r_init_done <= 1'b1;
      end
    end
  end

  assign lcd_d     = r_d;
  assign lcd_rs    = r_rs;
  assign lcd_e     = r_e;
  assign init_done = r_init_done;
  assign busy      = (r_state != S_IDLE) || !w_empty || r_e;

endmodule

// File: tb/tb_lcd4_stream_ctrl.sv
// Directed bench for lcd4_stream_ctrl: captures every E pulse with its nibble,
// rise cycle and width, and compares against hand-computed expectations.
module tb_lcd4_stream_ctrl;

  localparam int CLK_DIV = 8;
  localparam int E_WIDTH = 2;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] lcd_d;
  logic       lcd_rs;
  logic       lcd_e;
  logic       init_done;
  logic       busy;

  lcd4_stream_ctrl #(.CLK_DIV(CLK_DIV), .E_WIDTH(E_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_data(in_data), .lcd_d(lcd_d), .lcd_rs(lcd_rs),
    .lcd_e(lcd_e), .init_done(init_done), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // pulse monitor: cyc k is the cycle whose falling edge is the k-th
  typedef struct {
    logic [4:0] nib;
    int         rise;
    int         width;
  } pulse_t;

  int     cyc = 0;
  pulse_t pq[$];
  pulse_t cur;
  logic   prev_e = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (lcd_e && !prev_e) begin
      cur.nib   = {lcd_rs, lcd_d};
      cur.rise  = cyc;
      cur.width = 1;
    end else if (lcd_e) begin
      cur.width++;
    end else if (prev_e) begin
      pq.push_back(cur);
    end
    prev_e = lcd_e;
  end

  // scoreboard counters
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // driver tasks; all return at posedge+1
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // after goto(k) the DUT outputs show their cycle-k values
  task automatic goto(input int k);
    while (cyc < k - 1) step();
  endtask

  task automatic do_reset(output int rel);
    rst_n = 1'b0;
    in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    rel = cyc + 1;
    pq.delete();
  endtask

  task automatic push(input logic rs, input logic [7:0] d, output logic acc);
    in_valid = 1'b1;
    in_rs = rs;
    in_data = d;
    acc = in_ready;
    step();
    in_valid = 1'b0;
  endtask

  task automatic get_pulse(output pulse_t p);
    int g = 0;
    while (pq.size() == 0 && g < 64) begin
      step();
      g++;
    end
    if (pq.size() == 0) begin
      check("pulse_timeout", pq.size(), 1);
      p.nib = '1;
      p.rise = -1;
      p.width = 0;
    end else begin
      p = pq.pop_front();
    end
  endtask

  task automatic expect_pulse(input string name, input logic [4:0] nib, input int rise,
                              output int got_rise);
    pulse_t p;
    get_pulse(p);
    check({name, "_nib"}, p.nib, nib);
    check({name, "_width"}, p.width, E_WIDTH);
    if (rise >= 0) check({name, "_rise"}, p.rise, rise);
    got_rise = p.rise;
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] hi;
    logic [4:0] lo;
  } vec_t;

  vec_t       tab[5];
  logic [3:0] init_tab[4];
  logic [7:0] fill_tab[4];
  int         rel;
  int         r;
  int         c;
  int         g;
  logic       acc;

  initial begin
    tab[0] = '{rs: 1'b1, data: 8'h48, hi: 5'h14, lo: 5'h18};
    tab[1] = '{rs: 1'b0, data: 8'h01, hi: 5'h00, lo: 5'h01};
    tab[2] = '{rs: 1'b1, data: 8'h5A, hi: 5'h15, lo: 5'h1A};
    tab[3] = '{rs: 1'b0, data: 8'hFF, hi: 5'h0F, lo: 5'h0F};
    tab[4] = '{rs: 1'b1, data: 8'h80, hi: 5'h18, lo: 5'h10};
    init_tab[0] = 4'h3; init_tab[1] = 4'h2; init_tab[2] = 4'h0; init_tab[3] = 4'hE;
    fill_tab[0] = 8'h41; fill_tab[1] = 8'h42; fill_tab[2] = 8'h43; fill_tab[3] = 8'h44;

    // reset values
    step(); step();
    check("rst_lcd_d", lcd_d, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_e", lcd_e, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 1);
    check("rst_in_ready", in_ready, 1);

    // init sequence
    do_reset(rel);
    goto(rel + 24);
    check("init_done_before_k3", init_done, 0);
    goto(rel + 25);
    check("init_done_with_k3", init_done, 1);
    check("k3_on_bus", lcd_d, 4'hE);
    goto(rel + 60);
    check("busy_after_init", busy, 0);
    check("init_pulse_count", pq.size(), 4);
    for (int i = 0; i < 4; i++)
      expect_pulse("init", {1'b0, init_tab[i]}, rel + 2 + 8 * i, r);

    // single bytes from the vector table
    for (int i = 0; i < 5; i++) begin
      push(tab[i].rs, tab[i].data, acc);
      check("vec_accept", acc, 1);
      expect_pulse("vec_hi", tab[i].hi, -1, r);
      expect_pulse("vec_lo", tab[i].lo, r + 8, r);
      check("vec_busy_after", busy, 0);
    end

    // mixed rs back-to-back
    push(1'b0, 8'h01, acc);
    push(1'b1, 8'h5A, acc);
    expect_pulse("mix0", 5'h00, -1, r);
    expect_pulse("mix1", 5'h01, r + 8, r);
    expect_pulse("mix2", 5'h15, r + 8, r);
    expect_pulse("mix3", 5'h1A, r + 8, r);

    // fill the FIFO during init
    do_reset(rel);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, fill_tab[i], acc);
      check("fill_accept", acc, 1);
    end
    check("fill_in_ready_full", in_ready, 0);
    push(1'b1, 8'h45, acc);
    check("fill_fifth_rejected", acc, 0);
    for (int i = 0; i < 4; i++)
      expect_pulse("fill_init", {1'b0, init_tab[i]}, rel + 2 + 8 * i, r);
    for (int i = 0; i < 4; i++) begin
      expect_pulse("fill_hi", 5'h14, rel + 2 + 8 * (4 + 2 * i), r);
      expect_pulse("fill_lo", {1'b1, fill_tab[i][3:0]}, rel + 2 + 8 * (5 + 2 * i), r);
    end
    goto(cyc + 24);
    check("fill_drained_busy", busy, 0);
    check("fill_no_extra", pq.size(), 0);

    // reset during the E-high cycle of a high nibble
    push(1'b1, 8'h12, acc);
    push(1'b1, 8'h34, acc);
    push(1'b1, 8'h56, acc);
    g = 0;
    while (!lcd_e && g < 40) begin
      step();
      g++;
    end
    check("mid_e_seen", lcd_e, 1);
    check("mid_hi_nib", lcd_d, 4'h1);
    rst_n = 1'b0;
    step();
    check("mid_rst_e", lcd_e, 0);
    check("mid_rst_d", lcd_d, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_init_done", init_done, 0);
    step(); step();
    rst_n = 1'b1;
    rel = cyc + 1;
    pq.delete();
    for (int i = 0; i < 4; i++)
      expect_pulse("replay_init", {1'b0, init_tab[i]}, rel + 2 + 8 * i, r);
    goto(rel + 70);
    check("replay_queue_gone", pq.size(), 0);
    check("replay_busy", busy, 0);

    // push exactly in a t==0 cycle with the FIFO empty
    c = rel + 8 * ((cyc + 2 - rel + 7) / 8);
    goto(c);
    push(1'b0, 8'h9C, acc);
    check("pop_cycle_accept", acc, 1);
    expect_pulse("pop_cycle_hi", 5'h09, c + 10, r);
    expect_pulse("pop_cycle_lo", 5'h0C, c + 18, r);

    // push at t==3: high nibble goes out on the next slot start
    c = rel + 8 * ((cyc + 2 - rel + 7) / 8) + 3;
    goto(c);
    push(1'b1, 8'h3B, acc);
    expect_pulse("latency_hi", 5'h13, c + 7, r);
    expect_pulse("latency_lo", 5'h1B, c + 15, r);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
